// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, bit-period helper, frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Clock cycles per bit; integer division, same rounding as the receiver.
  function automatic int bit_cycles(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte write port of the buffered UART transmitter (CPU bus or harness side).
// Latency: a byte is accepted on the edge where wr && tx_ready.
// Backpressure: tx_ready low means the queue is full and writes are dropped.
interface uart_tx_buf_if;
  import uart_pkg::*;

  logic                      wr;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_ready;

  modport master (output wr, output tx_data, input tx_ready);
  modport slave  (input wr, input tx_data, output tx_ready);

endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO, power-of-two depth, head word readable without a read strobe.
// Latency: a write is visible at the head (and in level) one edge later.
// Backpressure: writes while full and reads while empty are ignored.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  // full/empty decode from the registered count, so a pop never unblocks a same-cycle write
  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign level = cnt;
  // head word comes straight out of the storage registers
  assign rdata = mem[rptr];

  // pointers wrap naturally at DEPTH; count tracks net writes minus reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // storage array; contents need no reset since cnt gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: queued bytes serialised LSB-first on tx.
// Latency: start bit begins one edge after the byte lands in an empty queue.
// Backpressure: tx_ready drops when the queue holds DEPTH bytes; extra writes are lost.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ = 100_000,
  parameter int BAUD     = 1_000,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_buf_if.slave           bus,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int BC       = bit_cycles(CLOCK_HZ, BAUD);
  localparam int BCW      = (BC > 1) ? $clog2(BC) : 1;
  localparam int BITW     = $clog2(UART_DATA_BITS);
  localparam int LAST_BIT = UART_DATA_BITS - 1;

  uart_tx_state_t            state, state_nxt;
  logic [BCW-1:0]            baudcnt, baudcnt_nxt;
  logic [BITW-1:0]           bitcnt, bitcnt_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                      tx_q, tx_nxt;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      bit_end;
  logic [UART_DATA_BITS-1:0] head;

  fifo_sync #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (bus.wr),
    .rd    (pop),
    .wdata (bus.tx_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.tx_ready = !full;
  assign bit_end      = (baudcnt == BCW'(BC - 1));
  assign tx           = tx_q;
  assign busy         = (state != IDLE) || !empty;

  // next-state, pop and line level; tx is registered so it never glitches
  always_comb begin
    state_nxt   = state;
    baudcnt_nxt = baudcnt;
    bitcnt_nxt  = bitcnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx_q;
    pop         = 1'b0;
    if (state != IDLE) baudcnt_nxt = bit_end ? '0 : baudcnt + 1'b1;
    case (state)
      IDLE: begin
        baudcnt_nxt = '0;
        tx_nxt      = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shreg_nxt  = head;
          bitcnt_nxt = '0;
          tx_nxt     = 1'b0;
          state_nxt  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bitcnt == BITW'(LAST_BIT)) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shreg_nxt  = shreg >> 1;
            tx_nxt     = shreg[1];
            bitcnt_nxt = bitcnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            // back-to-back: next start bit follows the last stop cycle directly
            pop        = 1'b1;
            shreg_nxt  = head;
            bitcnt_nxt = '0;
            tx_nxt     = 1'b0;
            state_nxt  = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      baudcnt <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      baudcnt <= baudcnt_nxt;
      bitcnt  <= bitcnt_nxt;
      shreg   <= shreg_nxt;
      tx_q    <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: frame vectors, burst/full, write+pop, reset mid-frame.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_buf;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx1, tx2, busy1, busy2;
  logic [4:0] level1, level2;
  logic       sel;
  logic       mon_tx, mon_busy;
  logic [4:0] mon_level;
  int         checks = 0;
  int         errors = 0;
  int         ofs = 0;

  always #5 clk = ~clk;

  uart_tx_buf_if bus1();
  uart_tx_buf_if bus2();

  uart_tx_buf dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .tx(tx1), .busy(busy1), .level(level1)
  );

  uart_tx_buf #(.CLOCK_HZ(50), .BAUD(10), .DEPTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .tx(tx2), .busy(busy2), .level(level2)
  );

  assign mon_tx    = sel ? tx2 : tx1;
  assign mon_busy  = sel ? busy2 : busy1;
  assign mon_level = sel ? level2 : level1;

  typedef struct {
    bit         sel;    // 0: defaults (100 cycles/bit), 1: 5 cycles/bit
    logic [7:0] data;
    logic [9:0] frame;  // line level per bit period, index 0 = start bit
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    ofs += n;
  endtask

  task automatic goto(input int t);
    if (t > ofs) step(t - ofs);
  endtask

  task automatic put(input bit s, input logic [7:0] d);
    if (s) begin bus2.wr = 1'b1; bus2.tx_data = d; end
    else   begin bus1.wr = 1'b1; bus1.tx_data = d; end
  endtask

  task automatic clr();
    bus1.wr = 1'b0;
    bus2.wr = 1'b0;
  endtask

  // Sample the line at each bit centre of a frame whose start bit begins at ofs == base.
  task automatic rx_frame(input int base, input int bc, output logic [9:0] fr);
    for (int i = 0; i < UART_FRAME_BITS; i++) begin
      goto(base + i * bc + bc / 2);
      fr[i] = mon_tx;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] d;
    int         lat;
    int         bc;
    int         lows;

    vecs[0] = '{1'b0, 8'h41, 10'b1010000010};
    vecs[1] = '{1'b0, 8'hA5, 10'b1101001010};
    vecs[2] = '{1'b0, 8'h00, 10'b1000000000};
    vecs[3] = '{1'b0, 8'hFF, 10'b1111111110};
    vecs[4] = '{1'b1, 8'h0D, 10'b1000011010};
    vecs[5] = '{1'b1, 8'h3C, 10'b1001111000};

    sel = 1'b0;
    rst_n = 1'b0;
    bus1.wr = 1'b0; bus1.tx_data = 8'h00;
    bus2.wr = 1'b0; bus2.tx_data = 8'h00;
    step(3);
    check("rst_tx", tx1, 1'b1);
    check("rst_tx_ready", bus1.tx_ready, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_level", level1, 5'd0);
    check("rst_tx_small", tx2, 1'b1);
    rst_n = 1'b1;
    step(2);

    // ---- single-frame vectors
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      bc  = sel ? 5 : 100;
      d   = vecs[v].data;
      put(sel, d);
      step(1);
      clr();
      if (sel) bus2.tx_data = ~d; else bus1.tx_data = ~d;
      check("vec_level_after_wr", mon_level, 5'd1);
      lat = 1;
      while (mon_tx !== 1'b0 && lat < 20) begin
        step(1);
        lat++;
      end
      check("vec_fall_latency", lat, 2);
      ofs = 0;
      check("vec_level_after_pop", mon_level, 5'd0);
      rx_frame(0, bc, fr);
      check("vec_frame", fr, vecs[v].frame);
      check("vec_rx_data", fr[8:1], d);
      goto(UART_FRAME_BITS * bc - 1);
      check("vec_busy_last", mon_busy, 1'b1);
      goto(UART_FRAME_BITS * bc);
      check("vec_busy_drop", mon_busy, 1'b0);
      check("vec_tx_idle", mon_tx, 1'b1);
      step(3);
    end

    // ---- burst of 17 bytes, queue fills, full writes dropped
    sel = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      bus1.wr = 1'b1;
      bus1.tx_data = k[7:0];
      step(1);
      if (k == 1) begin
        check("burst_fall", tx1, 1'b0);
        ofs = 0;
      end
    end
    clr();
    check("burst_level_full", level1, 5'd16);
    check("burst_tx_ready", bus1.tx_ready, 1'b0);
    put(0, 8'h99);
    step(1);
    clr();
    check("burst_full_drop", level1, 5'd16);
    for (int k = 0; k <= 16; k++) begin
      rx_frame(k * 1000, 100, fr);
      check("burst_frame", fr, {1'b1, k[7:0], 1'b0});
      goto(k * 1000 + 999);
      check("burst_stop", tx1, 1'b1);
      if (k == 0) put(0, 8'hEE);  // coincides with a pop while still full
      goto(k * 1000 + 1000);
      if (k == 0) begin
        clr();
        check("burst_full_pop_drop", level1, 5'd15);
      end
      if (k < 16) check("burst_no_gap", tx1, 1'b0);
      else begin
        check("burst_busy_end", busy1, 1'b0);
        check("burst_level_end", level1, 5'd0);
      end
    end
    step(3);

    // ---- write coinciding with the STOP->START pop
    put(0, 8'h11);
    step(1);
    clr();
    step(1);
    check("simul_fall", tx1, 1'b0);
    ofs = 0;
    goto(10);
    put(0, 8'h22);
    step(1);
    clr();
    check("simul_level_pre", level1, 5'd1);
    for (int k = 0; k < 3; k++) begin
      rx_frame(k * 1000, 100, fr);
      d = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33;
      check("simul_frame", fr, {1'b1, d, 1'b0});
      goto(k * 1000 + 999);
      if (k == 0) put(0, 8'h33);
      goto(k * 1000 + 1000);
      if (k == 0) begin
        clr();
        check("simul_level_hold", level1, 5'd1);
      end
      if (k == 1) check("simul_level_drain", level1, 5'd0);
      if (k == 2) check("simul_busy_end", busy1, 1'b0);
    end
    step(3);

    // ---- reset in the middle of a frame
    put(0, 8'hFF);
    step(1);
    clr();
    step(1);
    check("rstmid_fall", tx1, 1'b0);
    ofs = 0;
    for (int k = 1; k <= 4; k++) begin
      put(0, k[7:0]);
      step(1);
    end
    clr();
    check("rstmid_queued", level1, 5'd4);
    goto(450);
    check("rstmid_bit3", tx1, 1'b1);
    rst_n = 1'b0;
    step(1);
    check("rstmid_tx", tx1, 1'b1);
    check("rstmid_level", level1, 5'd0);
    check("rstmid_busy", busy1, 1'b0);
    check("rstmid_tx_ready", bus1.tx_ready, 1'b1);
    rst_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if (tx1 !== 1'b1) lows++;
    end
    check("rstmid_no_frames", lows, 0);
    check("rstmid_idle_busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
